// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i front end (fetch and decode).
package rv32i_pkg;

  localparam int          XLEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Word-aligns an address by clearing its byte-offset bits.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, instr} pairs between fetch and decode.
// Power-of-two depth so the read/write pointers wrap naturally.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [PTR_W:0] count,
  output fetch_entry_t head
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;
  fetch_entry_t     slots [FIFO_DEPTH];

  always_comb begin
    do_push  = push & ~flush;
    do_pop   = pop & ~flush & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      fetch_entry_t slot_q;
      logic         wr_en;

      assign wr_en = do_push && (wr_ptr_q == PTR_W'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_q <= '0;
        end else if (wr_en) begin
          slot_q <= push_entry;
        end
      end

      assign slots[gi] = slot_q;
    end
  endgenerate

  assign count = count_q;
  assign head  = slots[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// rv32i instruction fetch: owns the PC, one outstanding imem read, buffered output to decode.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky fetch_fault for misaligned redirect targets.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   redir_target;
  logic          stop_issue;

  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  fifo_head;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after_pop;
  logic          can_issue;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    redir_target = redirect_pc;
    fault_d      = fault_q | (redirect_valid & (redirect_pc[1:0] != 2'b00));
    stop_issue   = fault_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  always_comb begin
    redir_target = pc_align(redirect_pc);
    stop_issue   = 1'b0;
  end
`endif

  // A redirect outranks the pop, so decode never sees a handshake in that cycle.
  assign fifo_pop        = instr_valid & instr_ready & ~redirect_valid;
  assign count_after_pop = fifo_count - CW'(fifo_pop);
  // rst gates issue so imem_req stays low while reset is held.
  assign can_issue       = rst & ~redirect_valid & ~stop_issue &
                           (count_after_pop < CW'(FIFO_DEPTH));

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    req_pc_d         = req_pc_q;
    imem_req         = 1'b0;
    fifo_push        = 1'b0;
    push_entry.pc    = req_pc_q;
    push_entry.instr = imem_rdata;

    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redir_target;
        end else if (can_issue) begin
          imem_req = 1'b1;
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redir_target;
          state_d = imem_valid ? IDLE : DRAIN;
        end else if (imem_valid) begin
          fifo_push = 1'b1;
          state_d   = IDLE;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_d = redir_target;
        end
        // The stale response is consumed here whatever else happens this cycle.
        if (imem_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .push_entry(push_entry),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign imem_addr   = pc_q;
  assign instr_valid = (fifo_count != '0);
  assign instr       = instr_valid ? fifo_head.instr : 32'h0;
  assign instr_pc    = instr_valid ? fifo_head.pc    : 32'h0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the rv32i core; sits directly upstream of decode, which splits the instruction word and feeds ImmSignExtend.
- Owns the PC and issues word reads to instruction memory, one request outstanding at a time.
- Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute: flushes the buffer and discards any in-flight stale response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, entries in the instruction buffer (power of two, >=2).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  one-cycle read request pulse.
- imem_addr  out  32  word address for the request; valid while imem_req=1.
- imem_valid  in  1  response strobe; arrives >=1 cycle after imem_req.
- imem_rdata  in  32  instruction word; valid while imem_valid=1.
- instr_valid  out  1  buffer head valid.
- instr  out  32  head instruction word.
- instr_pc  out  32  PC of the head instruction.
- instr_ready  in  1  decode accepts the head.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  32  redirect target.

Behaviour:
- Reset (async, rst=0): pc=RESET_PC, state=IDLE, FIFO empty. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- States:
  - IDLE: issue when the FIFO has a free slot, i.e. count < FIFO_DEPTH after this cycle's pop. Issue drives imem_req=1 and imem_addr=pc, latches req_pc=pc, sets pc+=4, and moves to WAIT.
  - WAIT: on imem_valid, push {req_pc, imem_rdata} and go to IDLE. Earliest next issue is the following cycle, so peak throughput is 1 instruction per 2 cycles.
  - DRAIN: on imem_valid, drop the data, do not push, and go to IDLE.
- Latency: imem_valid in cycle N gives instr_valid=1 in cycle N+1 when the FIFO was empty. There is no combinational bypass.
- Pop: occurs when instr_valid && instr_ready. Simultaneous push and pop is legal at any fill level. Overflow is impossible by construction because a slot is reserved at issue.
- Redirect:
  - redirect_valid has priority over push, pop and issue in the same cycle.
  - Effect: FIFO flushed (instr_valid=0 next cycle), pc=redirect_pc, no issue that cycle.
  - From IDLE: stay in IDLE; issue to redirect_pc next cycle.
  - From WAIT: go to DRAIN. If imem_valid arrives in the same cycle as the redirect, drop that response and go straight to IDLE.
  - From DRAIN: update pc and stay in DRAIN.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- imem_rdata is sampled only when imem_valid=1 in WAIT. A stray imem_valid in IDLE is ignored.
- Reset asserted mid-request: return to the reset state immediately. The memory side must also be reset, so no response is expected afterwards.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output port fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault sticky until reset and flushes the FIFO.
  - Issuing stops; a DRAIN in progress still completes.
- Undefined: no port; redirect_pc[1:0] is forced to 2'b00.

Decomposition:
- rv32i_pkg gets:
  - fetch_state_t enum {IDLE, WAIT, DRAIN}.
  - typedef fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - localparam XLEN=32 and PC_STEP=4.
- Sub-module fetch_fifo:
  - Parameterised FIFO_DEPTH over fetch_entry_t.
  - Signals: push, pop, flush, count, head.
  - Has its own async active-low reset.

Test Plan:
- Reset release, memory with 1-cycle latency returning 32'hFFC4A303 at addr 0 → imem_req at addr 0, then 4, then 8. instr_valid=1 with instr=32'hFFC4A303, instr_pc=0 one cycle after imem_valid.
- instr_ready=0 with FIFO_DEPTH=2 → exactly 2 requests issued (addrs 0, 4), then imem_req held 0. Raise ready → entries pop in order (pc 0, then 4) and fetch resumes at addr 8.
- Redirect to 32'h100 while in WAIT with a 3-cycle memory → the stale response is dropped and the FIFO is empty. Next request at 32'h100; instr_pc=32'h100 with instr=32'h0064A423.
- Redirect in the same cycle as imem_valid and a pop → nothing pushed, FIFO flushed, next imem_addr=redirect_pc.
- RESET_PC=32'hFFFF_FFF8, ready=1 → imem_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With FETCH_MISALIGN_CHECK_EN: redirect_pc=32'h102 → fetch_fault=1 next cycle, no further imem_req, instr_valid=0. Without the macro: fetch restarts at 32'h100.
